// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver files.
//   * legal ranges for the DATA_BITS, OVERSAMPLE and STOP_BITS parameters
//   * receiver FSM state encoding (plain 3-bit constants so older code that
//     compares against raw state values keeps working)
//   * majority3(): 2-of-3 vote used to decide each bit
package uart_pkg;

   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 9;
   localparam int OVERSAMPLE_MIN = 8;
   localparam int OVERSAMPLE_MAX = 64;
   localparam int STOP_BITS_MIN  = 1;
   localparam int STOP_BITS_MAX  = 2;

   typedef logic [2:0] rx_state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- line synchroniser, start-edge detector and bit voter.
// Ports:
//   rx_clock    in   receiver clock, rising edge
//   rx_reset_n  in   asynchronous active-low reset
//   rx_input    in   raw asynchronous serial line (idle high)
//   tick        in   oversample tick position within the current bit
//   line_fall   out  synchronised high-to-low transition seen this cycle
//   vote        out  2-of-3 majority of the samples at ticks MID-1, MID, MID+1;
//                    stable from tick MID+2 until the next bit's sampling
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
)(
   input  logic                          rx_clock,
   input  logic                          rx_reset_n,
   input  logic                          rx_input,
   input  logic [$clog2(OVERSAMPLE)-1:0] tick,
   output logic                          line_fall,
   output logic                          vote
);

   localparam int TW  = $clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2;

   logic [1:0] sync_reg;
   logic       line_sync;
   logic [1:0] flush_reg;
   logic       prev_reg;

   // The synchroniser resets to idle-high. Its reset value must not be
   // mistaken for real line history, otherwise a line that is already low
   // when reset is released would look like a fresh start edge. prev_reg
   // therefore only tracks the line once the chain has been flushed.
   always_ff @(posedge rx_clock or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         sync_reg  <= 2'b11;
         flush_reg <= 2'd0;
         prev_reg  <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], rx_input};
         if (flush_reg != 2'd3)
            flush_reg <= flush_reg + 2'd1;
         prev_reg <= flush_reg[1] ? line_sync : 1'b0;
      end
   end

   assign line_sync = sync_reg[1];
   assign line_fall = prev_reg & ~line_sync;

   // One capture flop per sample point around the bit centre.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sample
         localparam logic [TW-1:0] SAMPLE_AT = TW'(MID - 1 + gi);
         logic sample_reg;

         always_ff @(posedge rx_clock or negedge rx_reset_n) begin
            if (!rx_reset_n)
               sample_reg <= 1'b1;
            else if (tick == SAMPLE_AT)
               sample_reg <= line_sync;
         end
      end
   endgenerate

   assign vote = majority3(g_sample[0].sample_reg, g_sample[1].sample_reg,
                           g_sample[2].sample_reg);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parameterised oversampling UART receiver.
// Ports:
//   rx_clock         in   single clock, all logic on the rising edge
//   rx_reset_n       in   asynchronous active-low reset
//   rx_enable        in   receiver enable; low aborts any frame
//   rx_input         in   asynchronous serial line, idle high
//   rx_ready         in   consumer accepts the held frame
//   rx_output        out  received data, LSB first on the line
//   rx_valid         out  rx_output holds an unconsumed frame
//   rx_busy          out  frame reception in progress
//   rx_parity_error  out  parity mismatch on the held frame
//   rx_frame_error   out  a stop bit sampled low on the held frame
//   rx_break         out  all-zero data with a low first stop bit
//   rx_overrun       out  one-cycle pulse when a completed frame is dropped
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
)(
   input  logic                 rx_clock,
   input  logic                 rx_reset_n,
   input  logic                 rx_enable,
   input  logic                 rx_input,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_output,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 rx_parity_error,
   output logic                 rx_frame_error,
   output logic                 rx_break,
   output logic                 rx_overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);
   // The third vote sample is registered at MID+1, so MID+2 is the first
   // tick at which the vote of the current bit is complete.
   localparam logic [TW-1:0] TICK_DECIDE = TW'(OVERSAMPLE / 2 + 2);
   localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);
   localparam logic          HAS_PARITY  = (PARITY_EN != 0);
   localparam logic          ODD         = (PARITY_ODD != 0);

   generate
      if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
          OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
          (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
          STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_params
         $error("uart_rx_param: parameter outside its legal range");
      end
   endgenerate

   rx_state_t            state_reg, state_next;
   logic [TW-1:0]        tick_reg, tick_next;
   logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 parity_flag_reg, parity_flag_next;
   logic                 frame_flag_reg, frame_flag_next;
   logic                 break_flag_reg, break_flag_next;
   logic                 busy_reg, busy_next;
   logic [DATA_BITS-1:0] out_reg, out_next;
   logic                 valid_reg, valid_next;
   logic                 perr_reg, perr_next;
   logic                 ferr_reg, ferr_next;
   logic                 brk_reg, brk_next;
   logic                 overrun_reg, overrun_next;

   logic complete;
   logic tick_wrap;
   logic decide;
   logic line_fall;
   logic vote;

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .rx_clock   (rx_clock),
      .rx_reset_n (rx_reset_n),
      .rx_input   (rx_input),
      .tick       (tick_reg),
      .line_fall  (line_fall),
      .vote       (vote)
   );

   always_comb begin
      state_next       = state_reg;
      tick_next        = tick_reg;
      bit_cnt_next     = bit_cnt_reg;
      stop_cnt_next    = stop_cnt_reg;
      shift_next       = shift_reg;
      parity_flag_next = parity_flag_reg;
      frame_flag_next  = frame_flag_reg;
      break_flag_next  = break_flag_reg;
      busy_next        = busy_reg;
      complete         = 1'b0;

      tick_wrap = (tick_reg == TICK_LAST);
      decide    = (tick_reg == TICK_DECIDE);

      if (state_reg != ST_IDLE)
         tick_next = tick_wrap ? '0 : tick_reg + 1'b1;

      case (state_reg)
         ST_IDLE: begin
            tick_next     = '0;
            bit_cnt_next  = '0;
            stop_cnt_next = 1'b0;
            if (line_fall) begin
               state_next       = ST_START;
               busy_next        = 1'b1;
               parity_flag_next = 1'b0;
               frame_flag_next  = 1'b0;
               break_flag_next  = 1'b0;
            end
         end
         ST_START: begin
            // A start bit that votes high was a glitch: drop it silently.
            if (decide && vote) begin
               state_next = ST_IDLE;
               busy_next  = 1'b0;
               tick_next  = '0;
            end else if (tick_wrap) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            // LSB arrives first, so shift in from the top.
            if (decide)
               shift_next = {vote, shift_reg[DATA_BITS-1:1]};
            if (tick_wrap) begin
               if (bit_cnt_reg == BIT_LAST) begin
                  bit_cnt_next = '0;
                  state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (decide)
               parity_flag_next = (vote != ((^shift_reg) ^ ODD));
            if (tick_wrap)
               state_next = ST_STOP;
         end
         ST_STOP: begin
            if (decide) begin
               if (!vote)
                  frame_flag_next = 1'b1;
               if (stop_cnt_reg == 1'b0)
                  break_flag_next = (shift_reg == '0) && !vote;
               // Finish at mid stop bit so a start edge in the rest of the
               // stop period is still caught from IDLE.
               if (stop_cnt_reg == STOP_LAST) begin
                  complete   = 1'b1;
                  state_next = ST_IDLE;
                  busy_next  = 1'b0;
                  tick_next  = '0;
               end
            end
            if (tick_wrap)
               stop_cnt_next = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            tick_next  = '0;
         end
      endcase

      if (!rx_enable) begin
         state_next    = ST_IDLE;
         busy_next     = 1'b0;
         tick_next     = '0;
         bit_cnt_next  = '0;
         stop_cnt_next = 1'b0;
         complete      = 1'b0;
      end
   end

   // Hand-off: a finished frame replaces the held one only if the slot is
   // free or being consumed in this very cycle; otherwise it is dropped.
   always_comb begin
      out_next     = out_reg;
      perr_next    = perr_reg;
      ferr_next    = ferr_reg;
      brk_next     = brk_reg;
      valid_next   = valid_reg & ~rx_ready;
      overrun_next = 1'b0;
      if (complete) begin
         if (!valid_reg || rx_ready) begin
            out_next   = shift_reg;
            perr_next  = parity_flag_reg;
            ferr_next  = frame_flag_next;
            brk_next   = break_flag_next;
            valid_next = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end
   end

   always_ff @(posedge rx_clock or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         state_reg       <= ST_IDLE;
         tick_reg        <= '0;
         bit_cnt_reg     <= '0;
         stop_cnt_reg    <= 1'b0;
         shift_reg       <= '0;
         parity_flag_reg <= 1'b0;
         frame_flag_reg  <= 1'b0;
         break_flag_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         out_reg         <= '0;
         valid_reg       <= 1'b0;
         perr_reg        <= 1'b0;
         ferr_reg        <= 1'b0;
         brk_reg         <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         tick_reg        <= tick_next;
         bit_cnt_reg     <= bit_cnt_next;
         stop_cnt_reg    <= stop_cnt_next;
         shift_reg       <= shift_next;
         parity_flag_reg <= parity_flag_next;
         frame_flag_reg  <= frame_flag_next;
         break_flag_reg  <= break_flag_next;
         busy_reg        <= busy_next;
         out_reg         <= out_next;
         valid_reg       <= valid_next;
         perr_reg        <= perr_next;
         ferr_reg        <= ferr_next;
         brk_reg         <= brk_next;
         overrun_reg     <= overrun_next;
      end
   end

   assign rx_output       = out_reg;
   assign rx_valid        = valid_reg;
   assign rx_busy         = busy_reg;
   assign rx_parity_error = perr_reg;
   assign rx_frame_error  = ferr_reg;
   assign rx_break        = brk_reg;
   assign rx_overrun      = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- scoreboard bench for uart_rx_param.
// dut_a: 8N1, OVERSAMPLE=16.  dut_b: 7 data bits, even parity, 1 stop bit.
// Stimulus pushes the expected frame into a per-DUT queue before sending it;
// a monitor pops and compares at each rx_valid/rx_ready handshake.
module tb_uart_rx_param;

   localparam int OS = 16;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } frame_t;

   logic rx_clock = 1'b0;
   always #5 rx_clock = ~rx_clock;

   logic rx_reset_n;
   logic rx_enable;

   logic       line_a, ready_a;
   logic [7:0] out_a;
   logic       valid_a, busy_a, perr_a, ferr_a, brk_a, ovr_a;

   logic       line_b, ready_b;
   logic [6:0] out_b;
   logic       valid_b, busy_b, perr_b, ferr_b, brk_b, ovr_b;

   uart_rx_param dut_a (
      .rx_clock        (rx_clock),
      .rx_reset_n      (rx_reset_n),
      .rx_enable       (rx_enable),
      .rx_input        (line_a),
      .rx_ready        (ready_a),
      .rx_output       (out_a),
      .rx_valid        (valid_a),
      .rx_busy         (busy_a),
      .rx_parity_error (perr_a),
      .rx_frame_error  (ferr_a),
      .rx_break        (brk_a),
      .rx_overrun      (ovr_a)
   );

   uart_rx_param #(
      .DATA_BITS  (7),
      .OVERSAMPLE (16),
      .PARITY_EN  (1),
      .PARITY_ODD (0),
      .STOP_BITS  (1)
   ) dut_b (
      .rx_clock        (rx_clock),
      .rx_reset_n      (rx_reset_n),
      .rx_enable       (rx_enable),
      .rx_input        (line_b),
      .rx_ready        (ready_b),
      .rx_output       (out_b),
      .rx_valid        (valid_b),
      .rx_busy         (busy_b),
      .rx_parity_error (perr_b),
      .rx_frame_error  (ferr_b),
      .rx_break        (brk_b),
      .rx_overrun      (ovr_b)
   );

   int     n_vec = 0;
   int     n_err = 0;
   frame_t q_a[$];
   frame_t q_b[$];
   int     ovr_cnt_a = 0;
   int     ovr_cnt_b = 0;

   function automatic frame_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
      frame_t r;
      r.data = d;
      r.perr = p;
      r.ferr = f;
      r.brk  = b;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_vec++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp_v);
      end else begin
         $display("check %s = 0x%0h ok", name, got);
      end
   endtask

   task automatic check_frame(input string tag, input frame_t got, input frame_t exp_f);
      n_vec++;
      if (got !== exp_f) begin
         n_err++;
         $display("FAIL frame_%s: got data=0x%0h p=%0b f=%0b b=%0b, expected data=0x%0h p=%0b f=%0b b=%0b",
                  tag, got.data, got.perr, got.ferr, got.brk,
                  exp_f.data, exp_f.perr, exp_f.ferr, exp_f.brk);
      end else begin
         $display("[%s] frame data=0x%0h p=%0b f=%0b b=%0b ok", tag, got.data, got.perr, got.ferr, got.brk);
      end
   endtask

   task automatic unexpected(input string tag, input frame_t got);
      n_vec++;
      n_err++;
      $display("FAIL frame_%s_unexpected: got data=0x%0h p=%0b f=%0b b=%0b, expected no frame",
               tag, got.data, got.perr, got.ferr, got.brk);
   endtask

   // Monitor: compare on every handshake, count overrun pulse cycles.
   initial begin
      frame_t g_a;
      frame_t g_b;
      forever begin
         @(negedge rx_clock);
         if (rx_reset_n && valid_a && ready_a) begin
            g_a = mk({1'b0, out_a}, perr_a, ferr_a, brk_a);
            if (q_a.size() == 0) unexpected("a", g_a);
            else check_frame("a", g_a, q_a.pop_front());
         end
         if (rx_reset_n && valid_b && ready_b) begin
            g_b = mk({2'b00, out_b}, perr_b, ferr_b, brk_b);
            if (q_b.size() == 0) unexpected("b", g_b);
            else check_frame("b", g_b, q_b.pop_front());
         end
         if (ovr_a) ovr_cnt_a++;
         if (ovr_b) ovr_cnt_b++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic set_line(input int which, input logic v);
      if (which == 0) line_a = v;
      else line_b = v;
   endtask

   task automatic send_bit(input int which, input logic v);
      set_line(which, v);
      repeat (OS) @(posedge rx_clock);
      #1;
   endtask

   task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                             input int use_par, input logic par, input logic stop);
      send_bit(which, 1'b0);
      for (int i = 0; i < nbits; i++) send_bit(which, data[i]);
      if (use_par != 0) send_bit(which, par);
      send_bit(which, stop);
      set_line(which, 1'b1);
   endtask

   task automatic idle(input int bits);
      repeat (bits * OS) @(posedge rx_clock);
      #1;
   endtask

   task automatic wait_drain(input int which, input string name);
      int n;
      n = 0;
      while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < 200) begin
         @(posedge rx_clock);
         n++;
      end
      #1;
      check(name, 32'((which == 0) ? q_a.size() : q_b.size()), 32'd0);
   endtask

   initial begin
      int n;
      rx_reset_n = 1'b0;
      rx_enable  = 1'b1;
      line_a     = 1'b1;
      line_b     = 1'b1;
      ready_a    = 1'b1;
      ready_b    = 1'b1;
      #3;
      check("reset_valid_a", 32'(valid_a), 32'd0);
      check("reset_busy_a",  32'(busy_a),  32'd0);
      check("reset_out_a",   32'(out_a),   32'd0);
      check("reset_flags_a", 32'({perr_a, ferr_a, brk_a, ovr_a}), 32'd0);
      check("reset_valid_b", 32'(valid_b), 32'd0);
      repeat (3) @(posedge rx_clock);
      #1;
      rx_reset_n = 1'b1;
      idle(2);

      // 8N1 data patterns
      q_a.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1);
      idle(1);
      wait_drain(0, "drain_a5");
      q_a.push_back(mk(9'h0FF, 1'b0, 1'b0, 1'b0));
      send_frame(0, 9'h0FF, 8, 0, 1'b0, 1'b1);
      q_a.push_back(mk(9'h001, 1'b0, 1'b0, 1'b0));
      send_frame(0, 9'h001, 8, 0, 1'b0, 1'b1);
      q_a.push_back(mk(9'h080, 1'b0, 1'b0, 1'b0));
      send_frame(0, 9'h080, 8, 0, 1'b0, 1'b1);
      idle(1);
      wait_drain(0, "drain_ff_01_80");

      // 7E1: 0x41 has two ones (parity bit 0), 0x07 has three (parity bit 1)
      q_b.push_back(mk(9'h041, 1'b1, 1'b0, 1'b0));
      send_frame(1, 9'h041, 7, 1, 1'b1, 1'b1);
      q_b.push_back(mk(9'h041, 1'b0, 1'b0, 1'b0));
      send_frame(1, 9'h041, 7, 1, 1'b0, 1'b1);
      q_b.push_back(mk(9'h007, 1'b0, 1'b0, 1'b0));
      send_frame(1, 9'h007, 7, 1, 1'b1, 1'b1);
      q_b.push_back(mk(9'h007, 1'b1, 1'b0, 1'b0));
      send_frame(1, 9'h007, 7, 1, 1'b0, 1'b1);
      idle(1);
      wait_drain(1, "drain_parity");

      // 5-tick glitch on an idle line
      set_line(0, 1'b0);
      repeat (5) @(posedge rx_clock);
      #1;
      set_line(0, 1'b1);
      check("glitch_busy_seen", 32'(busy_a), 32'd1);
      n = 0;
      while (busy_a && n < 10) begin
         @(negedge rx_clock);
         n++;
      end
      check("glitch_busy_clear", 32'(busy_a), 32'd0);
      idle(1);
      check("glitch_no_valid", 32'(valid_a), 32'd0);
      check("glitch_no_flags", 32'({perr_a, ferr_a, brk_a}), 32'd0);

      // break: 0x00 with a low stop bit
      q_a.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
      send_frame(0, 9'h000, 8, 0, 1'b0, 1'b0);
      idle(2);
      wait_drain(0, "drain_break");

      // enable dropped mid-frame aborts it
      fork
         send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1);
         begin
            repeat (OS * 4) @(posedge rx_clock);
            #2;
            check("abort_busy_before", 32'(busy_a), 32'd1);
            rx_enable = 1'b0;
            @(posedge rx_clock);
            #1;
            check("abort_busy_after", 32'(busy_a), 32'd0);
         end
      join
      idle(1);
      rx_enable = 1'b1;
      idle(1);
      check("abort_no_valid", 32'(valid_a), 32'd0);

      // overrun: 0x11 then 0x22 back-to-back while not ready
      ready_a = 1'b0;
      q_a.push_back(mk(9'h011, 1'b0, 1'b0, 1'b0));
      send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
      send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1);
      idle(1);
      check("ovr_pulse_cycles", 32'(ovr_cnt_a), 32'd1);
      check("ovr_hold_data", 32'(out_a), 32'h11);
      check("ovr_hold_valid", 32'(valid_a), 32'd1);
      ready_a = 1'b1;
      wait_drain(0, "drain_overrun");
      @(posedge rx_clock);
      #1;
      check("ovr_valid_cleared", 32'(valid_a), 32'd0);

      // reset pulse during the low data bits 6..7 of 0x3C
      fork
         send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1);
         begin
            repeat (OS * 7 + 4) @(posedge rx_clock);
            #2;
            check("rst_busy_before", 32'(busy_a), 32'd1);
            rx_reset_n = 1'b0;
            #1;
            check("rst_busy", 32'(busy_a), 32'd0);
            check("rst_out", 32'(out_a), 32'd0);
            repeat (3) @(posedge rx_clock);
            #2;
            rx_reset_n = 1'b1;
         end
      join
      idle(2);
      check("rst_no_spurious", 32'(valid_a), 32'd0);
      q_a.push_back(mk(9'h05A, 1'b0, 1'b0, 1'b0));
      send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1);
      idle(1);
      wait_drain(0, "drain_5a");

      idle(2);
      check("final_q_a", 32'(q_a.size()), 32'd0);
      check("final_q_b", 32'(q_b.size()), 32'd0);
      check("final_ovr_a", 32'(ovr_cnt_a), 32'd1);
      check("final_ovr_b", 32'(ovr_cnt_b), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
